alu_multicycle: RTL and testbench

//  Parametrised next-generation execute-stage ALU. Adds iterative MULT/MULTU/DIV/DIVU producing HI/LO.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_muldiv_core.sv | 120 ++++++++++++
 rtl/alu_multicycle.sv | 159 +++++++++++++++
 tb/tb_alu_multicycle.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and op classification helpers for the
// multi-cycle execute-stage ALU.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SRA   = 4'b0100;
    localparam logic [3:0] ALU_SLTU  = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_SLL   = 4'b1000;
    localparam logic [3:0] ALU_SRL   = 4'b1001;
    localparam logic [3:0] ALU_MULT  = 4'b1010;
    localparam logic [3:0] ALU_MULTU = 4'b1011;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_DIV   = 4'b1101;
    localparam logic [3:0] ALU_DIVU  = 4'b1110;
    localparam logic [3:0] ALU_RSVD  = 4'b1111;

    // Datapath mode of the shared iterative core
    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == ALU_MULT) || (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// Shared radix-2 datapath: shift-add multiply and restoring divide on operand
// magnitudes. One step is taken on the start edge and one per following cycle;
// done rises once WIDTH steps are complete, with sign fixup applied to hi/lo.
module alu_muldiv_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             start,
    input  logic             mode,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic             div_p0;
    logic             neg_lo_p0;
    logic             neg_hi_p0;
    logic [WIDTH-1:0] acc_p0;
    logic [WIDTH-1:0] quo_p0;
    logic [WIDTH-1:0] opb_p0;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? negate(v) : v;
    endfunction

    // One radix-2 step. Multiply: acc:quo is the partial product, quo shifts out
    // multiplier bits. Divide: acc is the partial remainder, quo shifts the
    // dividend out and quotient bits in.
    function automatic logic [2*WIDTH-1:0] step(input logic div,
                                                input logic [WIDTH-1:0] acc,
                                                input logic [WIDTH-1:0] quo,
                                                input logic [WIDTH-1:0] opb);
        logic [WIDTH:0] sum;
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] diff;
        sum     = {1'b0, acc} + {1'b0, (quo[0] ? opb : {WIDTH{1'b0}})};
        shifted = {acc, quo[WIDTH-1]};
        diff    = shifted - {1'b0, opb};
        if (div) begin
            if (diff[WIDTH])
                return {shifted[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
            else
                return {diff[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
        end
        return {sum, quo[WIDTH-1:1]};
    endfunction

    assign a_mag = magnitude(a, is_signed);
    assign b_mag = magnitude(b, is_signed);
    assign done  = busy && (cnt == LAST);

    // Iteration control: counts completed steps, cleared on abort or reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (abort) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CNT_W'(1);
        end else if (busy) begin
            if (cnt == LAST) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Datapath registers: first step folded into the load, then one step per cycle
    always_ff @(posedge clk) begin
        if (start) begin
            div_p0            <= mode;
            neg_lo_p0         <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi_p0         <= is_signed && a[WIDTH-1];
            opb_p0            <= b_mag;
            {acc_p0, quo_p0}  <= step(mode == MODE_DIV, '0, a_mag, b_mag);
        end else if (busy && (cnt != LAST)) begin
            {acc_p0, quo_p0}  <= step(div_p0 == MODE_DIV, acc_p0, quo_p0, opb_p0);
        end
    end

    // Sign fixup: product negated as a whole; quotient and remainder separately
    always_comb begin
        logic [2*WIDTH-1:0] prod;
        prod = {acc_p0, quo_p0};
        hi   = acc_p0;
        lo   = quo_p0;
        if (div_p0 == MODE_DIV) begin
            lo = neg_lo_p0 ? negate(quo_p0) : quo_p0;
            hi = neg_hi_p0 ? negate(acc_p0) : acc_p0;
        end else if (neg_lo_p0) begin
            prod = ~prod + (2*WIDTH)'(1);
            hi   = prod[2*WIDTH-1:WIDTH];
            lo   = prod[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU with valid/ready handshakes. Single-cycle ops register
// their result on the accept edge; mul/div run through alu_muldiv_core.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [3:0]       alu_control,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero
);

    state_t                   state;
    logic                     accept;
    logic                     core_done;
    logic [WIDTH-1:0]         core_hi;
    logic [WIDTH-1:0]         core_lo;
    logic [WIDTH-1:0]         alu_res;
    logic                     alu_ovf;
    logic [WIDTH-1:0]         a_p0;
    logic                     dbz_p0;
    logic signed [WIDTH-1:0]  a_s;
    logic signed [WIDTH-1:0]  b_s;
    logic [SHAMT_W-1:0]       shamt;

    // Signed overflow of a + b_eff, where b_eff is already inverted for SUB
    function automatic logic add_overflow(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b_eff,
                                          input logic [WIDTH-1:0] res);
        return (a[WIDTH-1] == b_eff[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
    endfunction

    assign a_s      = operand1;
    assign b_s      = operand2;
    assign shamt    = operand1[SHAMT_W-1:0];
    assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept   = in_valid && in_ready && !flush;

    alu_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (flush),
        .start     (accept && is_muldiv(alu_control)),
        .mode      (is_div(alu_control) ? MODE_DIV : MODE_MUL),
        .is_signed (is_signed_op(alu_control)),
        .a         (operand1),
        .b         (operand2),
        .done      (core_done),
        .hi        (core_hi),
        .lo        (core_lo)
    );

    // Single-cycle op results, evaluated directly on the presented operands
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (alu_control)
            ALU_AND:  alu_res = operand1 & operand2;
            ALU_OR:   alu_res = operand1 | operand2;
            ALU_XOR:  alu_res = operand1 ^ operand2;
            ALU_NOR:  alu_res = ~(operand1 | operand2);
            ALU_ADD: begin
                alu_res = operand1 + operand2;
                alu_ovf = add_overflow(operand1, operand2, alu_res);
            end
            ALU_SUB: begin
                alu_res = operand1 - operand2;
                alu_ovf = add_overflow(operand1, ~operand2, alu_res);
            end
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (operand1 < operand2)};
            ALU_SLL:  alu_res = operand2 << shamt;
            ALU_SRL:  alu_res = operand2 >> shamt;
            ALU_SRA:  alu_res = $unsigned(b_s >>> shamt);
            default:  alu_res = '0;
        endcase
    end

    // Operands needed after accept: divide-by-zero reports the dividend on hi
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0   <= operand1;
            dbz_p0 <= (operand2 == '0);
        end
    end

    // Control FSM with registered result, hi and flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            out_valid   <= 1'b0;
            result      <= '0;
            hi          <= '0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (flush) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (is_muldiv(alu_control)) begin
                            state     <= is_div(alu_control) ? ST_DIV : ST_MUL;
                            out_valid <= 1'b0;
                        end else begin
                            state       <= ST_DONE;
                            out_valid   <= 1'b1;
                            result      <= alu_res;
                            hi          <= '0;
                            // reserved code reports every flag low
                            zero        <= (alu_control != ALU_RSVD) && (alu_res == '0);
                            overflow    <= alu_ovf;
                            div_by_zero <= 1'b0;
                        end
                    end else if ((state == ST_DONE) && out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (core_done) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        overflow  <= 1'b0;
                        // divide by zero still runs the core so latency stays uniform
                        if ((state == ST_DIV) && dbz_p0) begin
                            result      <= '1;
                            hi          <= a_p0;
                            zero        <= 1'b0;
                            div_by_zero <= 1'b1;
                        end else begin
                            result      <= core_lo;
                            hi          <= core_hi;
                            zero        <= (core_lo == '0);
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Testbench for alu_multicycle (WIDTH=32): directed vector table, handshake
// and abort sequences, and random ops against an arithmetic reference model.
module tb_alu_multicycle;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [3:0]  alu_control;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [31:0] hi;
    logic        zero;
    logic        overflow;
    logic        div_by_zero;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] hi;
        logic        ovf;
        logic        dbz;
        logic        zero;
        logic        chk_zero;
        int          lat;
    } vec_t;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .operand1    (operand1),
        .operand2    (operand2),
        .alu_control (alu_control),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .hi          (hi),
        .zero        (zero),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached (compared %0d)", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input logic [31:0] h, input logic ovf,
                                input logic dbz, input logic z, input logic cz, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.hi = h;
        v.ovf = ovf; v.dbz = dbz; v.zero = z; v.chk_zero = cz; v.lat = lat;
        return v;
    endfunction

    // Reference model: exact integer arithmetic, then truncation to 32 bits
    function automatic vec_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        longint s;
        longint rm;
        logic [63:0] p;
        v = mk(op, a, b, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        case (op)
            ALU_AND:  v.res = a & b;
            ALU_OR:   v.res = a | b;
            ALU_XOR:  v.res = a ^ b;
            ALU_NOR:  v.res = ~(a | b);
            ALU_ADD: begin
                s = longint'($signed(a)) + longint'($signed(b));
                v.res = a + b;
                v.ovf = (s != longint'($signed(v.res)));
            end
            ALU_SUB: begin
                s = longint'($signed(a)) - longint'($signed(b));
                v.res = a - b;
                v.ovf = (s != longint'($signed(v.res)));
            end
            ALU_SLT:  v.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: v.res = (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:  v.res = b << a[4:0];
            ALU_SRL:  v.res = b >> a[4:0];
            ALU_SRA:  v.res = $unsigned($signed(b) >>> a[4:0]);
            ALU_MULT: begin
                s = longint'($signed(a)) * longint'($signed(b));
                p = s;
                v.hi = p[63:32]; v.res = p[31:0]; v.lat = 33;
            end
            ALU_MULTU: begin
                p = {32'h0, a} * {32'h0, b};
                v.hi = p[63:32]; v.res = p[31:0]; v.lat = 33;
            end
            ALU_DIV, ALU_DIVU: begin
                v.lat = 33;
                if (b == 32'h0) begin
                    v.res = 32'hFFFF_FFFF; v.hi = a; v.dbz = 1'b1;
                end else if (op == ALU_DIV) begin
                    s  = longint'($signed(a)) / longint'($signed(b));
                    rm = longint'($signed(a)) % longint'($signed(b));
                    p = s;  v.res = p[31:0];
                    p = rm; v.hi  = p[31:0];
                end else begin
                    v.res = a / b; v.hi = a % b;
                end
            end
            default: v.chk_zero = 1'b0;
        endcase
        v.zero = (v.res == 32'h0);
        return v;
    endfunction

    // Presents one op at a negedge with out_ready high; returns outputs and the
    // number of cycles (accept cycle counted as 1) until out_valid is seen.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic [31:0] h, output logic z,
                          output logic ov, output logic dz, output int lat);
        in_valid = 1'b1; alu_control = op; operand1 = a; operand2 = b; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; alu_control = 4'($urandom); operand1 = $urandom; operand2 = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        r = result; h = hi; z = zero; ov = overflow; dz = div_by_zero;
        @(negedge clk);
    endtask

    task automatic verify(input vec_t v, input string tag);
        logic [31:0] r, h;
        logic z, o, d;
        int lat;
        run_op(v.op, v.a, v.b, r, h, z, o, d, lat);
        check($sformatf("%s_lat", tag), 64'(lat), 64'(v.lat));
        check($sformatf("%s_result", tag), 64'(r), 64'(v.res));
        check($sformatf("%s_hi", tag), 64'(h), 64'(v.hi));
        check($sformatf("%s_overflow", tag), 64'(o), 64'(v.ovf));
        check($sformatf("%s_div_by_zero", tag), 64'(d), 64'(v.dbz));
        if (v.chk_zero) check($sformatf("%s_zero", tag), 64'(z), 64'(v.zero));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    vec_t vecs[$];
    logic [3:0] rand_ops[15] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_XOR, ALU_NOR, ALU_SLL,
                                 ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_MULT, ALU_MULTU,
                                 ALU_DIV, ALU_DIVU};

    initial begin
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        operand1 = '0; operand2 = '0; alu_control = '0;

        //                 op         a             b             result        hi            ovf   dbz   zero  chkz  lat
        vecs.push_back(mk(ALU_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1));
        vecs.push_back(mk(ALU_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 33));
        vecs.push_back(mk(ALU_MULTU, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 32'h00000004, 1'b0, 1'b0, 1'b0, 1'b1, 33));
        vecs.push_back(mk(ALU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 33));
        vecs.push_back(mk(ALU_DIVU,  32'h00000064, 32'h00000000, 32'hFFFFFFFF, 32'h00000064, 1'b0, 1'b1, 1'b0, 1'b1, 33));
        vecs.push_back(mk(ALU_DIV,   32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 33));
        vecs.push_back(mk(ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 33));
        vecs.push_back(mk(ALU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b1, 33));
        vecs.push_back(mk(ALU_MULT,  32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0, 1'b0, 1'b1, 1'b1, 33));
        vecs.push_back(mk(ALU_SRA,   32'h00000004, 32'h80000000, 32'hF8000000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1));
        vecs.push_back(mk(ALU_SRL,   32'h00000004, 32'h80000000, 32'h08000000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1));
        vecs.push_back(mk(ALU_SLL,   32'h0000001F, 32'h00000003, 32'h80000000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1));
        vecs.push_back(mk(ALU_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1));
        vecs.push_back(mk(ALU_SLTU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1));
        vecs.push_back(mk(ALU_SUB,   32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1));
        vecs.push_back(mk(ALU_ADD,   32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1));
        vecs.push_back(mk(ALU_SUB,   32'h00000005, 32'h00000005, 32'h00000000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1));
        vecs.push_back(mk(ALU_NOR,   32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1));
        vecs.push_back(mk(ALU_RSVD,  32'h00001234, 32'h00005678, 32'h00000000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_outputs", {result, hi}, 64'd0);
        check("reset_flags", {61'd0, zero, overflow, div_by_zero}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < vecs.size(); i++)
            verify(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: held output, blocked input, same-cycle handoff
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; alu_control = ALU_SLT;
        operand1 = 32'hFFFF_FFFF; operand2 = 32'h1;
        @(posedge clk); #1;
        alu_control = ALU_ADD; operand1 = 32'h3; operand2 = 32'h4;
        check("bp_slt_valid", 64'(out_valid), 64'd1);
        check("bp_slt_result", 64'(result), 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_result", c), 64'(result), 64'd1);
            check($sformatf("bp_hold%0d_valid", c), 64'(out_valid), 64'd1);
            check($sformatf("bp_hold%0d_in_ready", c), 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        alu_control = ALU_SLTU; operand1 = 32'hFFFF_FFFF; operand2 = 32'h1; out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_sltu_valid", 64'(out_valid), 64'd1);
        check("bp_sltu_result", 64'(result), 64'd0);
        check("bp_sltu_zero", 64'(zero), 64'd1);
        @(negedge clk);

        // Flush at cycle 10 of a DIV, with a competing in_valid
        in_valid = 1'b1; alu_control = ALU_DIV; operand1 = 32'hFFFF_FF9C; operand2 = 32'h7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; alu_control = ALU_ADD; operand1 = 32'h1; operand2 = 32'h2;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush_no_result", 64'(seen), 64'd0);
        @(negedge clk);

        // Reset in the middle of a MULT
        verify(model(ALU_ADD, 32'd5, 32'd6), "pre_reset_add");
        in_valid = 1'b1; alu_control = ALU_MULT; operand1 = 32'd7; operand2 = 32'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_mult_result_held", 64'(result), 64'd11);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_outputs", {result, hi}, 64'd0);
        check("rst_mid_flags", {61'd0, zero, overflow, div_by_zero}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("rst_mid_no_result", 64'(seen), 64'd0);
        @(negedge clk);

        // Random ops against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            op = rand_ops[$urandom_range(0, 14)];
            verify(model(op, pick_operand(), pick_operand()), $sformatf("rnd%0d_op%h", i, op));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
